// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the 4-state, K=3 Viterbi decoder.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int BM_W       = 2;

    typedef logic [BM_W-1:0] bm_t;

    // Predecessor of state n along branch k: the older input bit n[0] moves
    // into bit 1 and k is the bit that falls off the shift register.
    function automatic logic [1:0] pred(input logic [1:0] n, input logic k);
        return {n[0], k};
    endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// One add-compare-select cell: extends both candidate paths into a state,
// keeps the cheaper one and reports which predecessor won. Purely combinational.
module viterbi_acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm_k0,
    input  logic [PM_W-1:0] pm_k1,
    input  bm_t             bm_k0,
    input  bm_t             bm_k1,
    output logic [PM_W-1:0] pm_new,
    output logic            sel
);

    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;

    // Candidate metrics; the normalization bound keeps these sums from wrapping.
    always_comb begin
        c0     = pm_k0 + PM_W'(bm_k0);
        c1     = pm_k1 + PM_W'(bm_k1);
        // Strict compare so a tie keeps predecessor k=0.
        sel    = (c1 < c0);
        pm_new = sel ? c1 : c0;
    end

endmodule

// File: rtl/viterbi_pmu.sv
// Path-metric unit for the rate-1/2, K=3, 4-state Viterbi decoder.
// Holds the path-metric registers, the frame-start metric mux, MSB
// normalization and the registered survivor decisions.
// Optional feature: define VITERBI_PMU_BEST_STATE_EN to build the registered
// argmin (best_state); otherwise best_state is tied to state 0.
module viterbi_pmu
    import viterbi_pkg::*;
#(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             frame_start,
    input  bm_t  [2*NUM_STATES-1:0]          bm,
    output logic [NUM_STATES-1:0]            sel_out,
    output logic                             out_valid,
    output logic [NUM_STATES-1:0][PM_W-1:0]  pm_out,
    output logic [1:0]                       best_state
);

    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_d;
    logic [NUM_STATES-1:0]           sel_q, sel_d;
    logic                            out_valid_q, out_valid_d;

    logic [NUM_STATES-1:0][PM_W-1:0] old_pm;
    logic [NUM_STATES-1:0][PM_W-1:0] acs_pm;
    logic [NUM_STATES-1:0][PM_W-1:0] norm_pm;
    logic [NUM_STATES-1:0]           acs_sel;
    logic                            all_msb;

    // Old metrics: registered state, or the frame-start initial metrics.
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) begin
            if (frame_start) begin
                old_pm[i] = (i == 0) ? '0 : INIT_V;
            end else begin
                old_pm[i] = pm_q[i];
            end
        end
    end

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic [1:0] P0 = pred(2'(n), 1'b0);
        localparam logic [1:0] P1 = pred(2'(n), 1'b1);

        viterbi_acs_cell #(
            .PM_W (PM_W)
        ) u_acs (
            .pm_k0  (old_pm[P0]),
            .pm_k1  (old_pm[P1]),
            .bm_k0  (bm[2*n]),
            .bm_k1  (bm[2*n+1]),
            .pm_new (acs_pm[n]),
            .sel    (acs_sel[n])
        );
    end

    // Normalization: once every metric has crossed half range, drop the MSB
    // from all four; relative distances are unchanged.
    always_comb begin
        all_msb = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            all_msb = all_msb & acs_pm[i][PM_W-1];
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            norm_pm[i] = acs_pm[i];
            if (all_msb) begin
                norm_pm[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Next-state selection: advance on a valid step, otherwise hold.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        pm_d        = pm_q;
        sel_d       = sel_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            pm_d  = norm_pm;
            sel_d = acs_sel;
        end
    end

    // Metric and decision registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i] <= (i == 0) ? '0 : INIT_V;
            end
            sel_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pm_out    = pm_q;
    assign sel_out   = sel_q;
    assign out_valid = out_valid_q;

`ifdef VITERBI_PMU_BEST_STATE_EN
    logic [1:0]      best_q, best_d;
    logic [1:0]      arg_idx;
    logic [PM_W-1:0] arg_min;

    // Argmin over the new metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        arg_idx = 2'd0;
        arg_min = norm_pm[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (norm_pm[i] < arg_min) begin
                arg_min = norm_pm[i];
                arg_idx = 2'(i);
            end
        end
        best_d = in_valid ? arg_idx : best_q;
    end

    // Best-state register, updated alongside the metrics.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= 2'd0;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_state = best_q;
`else
    assign best_state = 2'b00;
`endif

endmodule

// File: tb/tb_viterbi_pmu.sv
// Self-checking bench for viterbi_pmu: a behavioural trellis model produces
// the expected outputs of every cycle into a scoreboard queue, which is
// popped and compared one cycle later.
module tb_viterbi_pmu;
    import viterbi_pkg::*;

    localparam int PM_W    = 8;
    localparam int INIT_PM = 16;

    typedef struct packed {
        logic [3:0]           sel;
        logic                 valid;
        logic [3:0][PM_W-1:0] pm;
        logic [1:0]           best;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     frame_start;
    bm_t  [7:0]               bm;
    logic [3:0]               sel_out;
    logic                     out_valid;
    logic [3:0][PM_W-1:0]     pm_out;
    logic [1:0]               best_state;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    // Reference model state
    int         m_pm[4];
    logic [3:0] m_sel;
    logic       m_valid;
    logic [1:0] m_best;

    viterbi_pmu #(
        .PM_W    (PM_W),
        .INIT_PM (INIT_PM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .bm          (bm),
        .sel_out     (sel_out),
        .out_valid   (out_valid),
        .pm_out      (pm_out),
        .best_state  (best_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = INIT_PM;
        m_sel   = '0;
        m_valid = 1'b0;
        m_best  = 2'd0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic fs, input bm_t [7:0] b);
        int  old[4];
        int  nw[4];
        int  c0, c1, base;
        bit  all_hi;
        if (r) begin
            model_reset();
        end else if (v) begin
            for (int i = 0; i < 4; i++) old[i] = fs ? ((i == 0) ? 0 : INIT_PM) : m_pm[i];
            all_hi = 1'b1;
            for (int n = 0; n < 4; n++) begin
                base     = (n % 2) * 2;
                c0       = old[base] + int'(b[2*n]);
                c1       = old[base + 1] + int'(b[2*n+1]);
                m_sel[n] = (c1 < c0);
                nw[n]    = (c1 < c0) ? c1 : c0;
                if (nw[n] < 128) all_hi = 1'b0;
            end
            for (int n = 0; n < 4; n++) m_pm[n] = all_hi ? nw[n] - 128 : nw[n];
            m_valid = 1'b1;
`ifdef VITERBI_PMU_BEST_STATE_EN
            m_best = 2'd0;
            for (int n = 1; n < 4; n++) if (m_pm[n] < m_pm[m_best]) m_best = 2'(n);
`else
            m_best = 2'd0;
`endif
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic fs, input bm_t [7:0] b);
        exp_t e;
        exp_t got;
        rst         = r;
        in_valid    = v;
        frame_start = fs;
        bm          = b;
        model_step(r, v, fs, b);
        for (int i = 0; i < 4; i++) e.pm[i] = PM_W'(m_pm[i]);
        e.sel   = m_sel;
        e.valid = m_valid;
        e.best  = m_best;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = sb_q.pop_front();
            check("pm_out", 64'(pm_out), 64'(got.pm));
            check("sel_out", 64'(sel_out), 64'(got.sel));
            check("out_valid", 64'(out_valid), 64'(got.valid));
            check("best_state", 64'(best_state), 64'(got.best));
        end
    endtask

    function automatic bm_t [7:0] bm_all(input bm_t v);
        bm_t [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v;
        return r;
    endfunction

    function automatic bm_t [7:0] bm_rand();
        bm_t [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = bm_t'($urandom_range(3, 0));
        return r;
    endfunction

    initial begin
        bm_t [7:0] alt;
        rst         = 1'b1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        bm          = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset values
        step(1'b1, 1'b0, 1'b0, bm_all(2'd0));
        check("reset_pm_const", 64'(pm_out), 64'({8'd16, 8'd16, 8'd16, 8'd0}));
        check("reset_sel_const", 64'(sel_out), 64'd0);

        // Two steps from reset with all-zero branch metrics
        step(1'b0, 1'b1, 1'b0, bm_all(2'd0));
        check("step1_pm_const", 64'(pm_out), 64'({8'd16, 8'd0, 8'd16, 8'd0}));
        step(1'b0, 1'b1, 1'b0, bm_all(2'd0));
        check("step2_pm_const", 64'(pm_out), 64'(32'd0));

        // Selection: the k=1 branch is cheaper everywhere, then ties
        for (int i = 0; i < 8; i++) alt[i] = (i % 2 == 0) ? 2'd2 : 2'd1;
        step(1'b0, 1'b1, 1'b0, alt);
        check("sel_all_one", 64'(sel_out), 64'hf);
        step(1'b0, 1'b1, 1'b0, bm_all(2'd1));
        check("tie_sel_zero", 64'(sel_out), 64'h0);
        check("tie_pm_two", 64'(pm_out), 64'({8'd2, 8'd2, 8'd2, 8'd2}));

        // Normalization from all-zero metrics
        step(1'b1, 1'b0, 1'b0, bm_all(2'd0));
        step(1'b0, 1'b1, 1'b0, bm_all(2'd0));
        step(1'b0, 1'b1, 1'b0, bm_all(2'd0));
        for (int s = 1; s <= 63; s++) step(1'b0, 1'b1, 1'b0, bm_all(2'd2));
        check("norm_pm_126", 64'(pm_out), 64'({8'd126, 8'd126, 8'd126, 8'd126}));
        step(1'b0, 1'b1, 1'b0, bm_all(2'd2));
        check("norm_pm_wrap0", 64'(pm_out), 64'(32'd0));

        // Random stream to move metrics apart
        for (int s = 0; s < 20; s++) step(1'b0, 1'b1, 1'b0, bm_rand());

        // Hold: in_valid low, bm and frame_start must be ignored
        for (int s = 0; s < 5; s++) step(1'b0, 1'b0, 1'b1, bm_rand());

        // Frame start overrides the previous metrics
        step(1'b0, 1'b1, 1'b1, bm_all(2'd0));
        check("frame_start_pm", 64'(pm_out), 64'({8'd16, 8'd0, 8'd16, 8'd0}));

        // Random stream exercising best_state and sel
        for (int s = 0; s < 30; s++) step(1'b0, 1'b1, 1'b0, bm_rand());

        // Mid-stream reset with a valid step in the same cycle
        step(1'b1, 1'b1, 1'b0, bm_rand());
        check("midreset_pm", 64'(pm_out), 64'({8'd16, 8'd16, 8'd16, 8'd0}));
        check("midreset_valid", 64'(out_valid), 64'd0);

        for (int s = 0; s < 10; s++) step(1'b0, 1'b1, ($urandom_range(3, 0) == 0), bm_rand());
        step(1'b0, 1'b0, 1'b0, bm_all(2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
